// File: rtl/dtw_sample_framer.sv
// Sample framer for the DTW front end: optional block-average decimation,
// ping-pong frame capture, and contiguous one-word-per-clock frame bursts.
module dtw_sample_framer #(
  parameter int FRAME_LEN = 20,
  parameter int DECIM     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        smp_valid_i,
  input  logic [9:0]  smp_x_i,
  input  logic [9:0]  smp_y_i,
  input  logic [9:0]  smp_z_i,
  input  logic        dtw_ready_i,
  output logic        valid_o,
  output logic [31:0] Sin_o,
  output logic        overflow_o,
  output logic [15:0] frame_cnt_o
);

  localparam int SH = $clog2(DECIM);
  localparam int AW = 10 + SH;
  localparam int PW = (SH > 0) ? SH : 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [AW-1:0] acc_x_r, acc_y_r, acc_z_r;
  logic [AW-1:0] sum_x_s, sum_y_s, sum_z_s;
  logic [PW-1:0] phase_r;
  logic          dec_valid_r;
  logic [29:0]   dec_data_r;

  logic [29:0]   mem_r [2][FRAME_LEN];
  logic [1:0]    full_r, full_nxt_s;
  logic          cap_r, cap_s, sel_s;
  logic          wr_en_s, wr_last_s, burst_end_s;
  logic [IW-1:0] wr_idx_r, rd_idx_r;
  logic          bank_r;
  state_t        state_r;

  // Accumulator sums, capture bank choice and full-flag next state
  always_comb begin
    sum_x_s = acc_x_r + AW'(smp_x_i);
    sum_y_s = acc_y_r + AW'(smp_y_i);
    sum_z_s = acc_z_r + AW'(smp_z_i);
    // A blocked pointer sits on a full bank; follow whichever bank frees up
    cap_s       = full_r[cap_r] ? ~cap_r : cap_r;
    wr_en_s     = dec_valid_r & ~full_r[cap_s];
    wr_last_s   = (wr_idx_r == IDX_LAST);
    burst_end_s = (state_r == BURST) && (rd_idx_r == IDX_LAST);
    if (full_r == 2'b11) begin
      sel_s = ~cap_r;
    end else begin
      sel_s = full_r[1] & ~full_r[0];
    end
    full_nxt_s = full_r;
    if (wr_en_s && wr_last_s) begin
      full_nxt_s[cap_s] = 1'b1;
    end else begin
      full_nxt_s[cap_s] = full_r[cap_s];
    end
    if (burst_end_s) begin
      full_nxt_s[bank_r] = 1'b0;
    end else begin
      full_nxt_s[bank_r] = full_nxt_s[bank_r];
    end
  end

  // Block-average decimator
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_x_r     <= '0;
      acc_y_r     <= '0;
      acc_z_r     <= '0;
      phase_r     <= '0;
      dec_valid_r <= 1'b0;
      dec_data_r  <= 30'd0;
    end else if (smp_valid_i) begin
      if (phase_r == PH_LAST) begin
        acc_x_r     <= '0;
        acc_y_r     <= '0;
        acc_z_r     <= '0;
        phase_r     <= '0;
        dec_valid_r <= 1'b1;
        dec_data_r  <= {10'(sum_x_s >> SH), 10'(sum_y_s >> SH), 10'(sum_z_s >> SH)};
      end else begin
        acc_x_r     <= sum_x_s;
        acc_y_r     <= sum_y_s;
        acc_z_r     <= sum_z_s;
        phase_r     <= phase_r + PW'(1);
        dec_valid_r <= 1'b0;
      end
    end else begin
      dec_valid_r <= 1'b0;
    end
  end

  // Frame storage
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[cap_s][wr_idx_r] <= dec_data_r;
    end
  end

  // Capture pointer, overflow flag and burst FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cap_r       <= 1'b0;
      wr_idx_r    <= IDX_ZERO;
      full_r      <= 2'b00;
      overflow_o  <= 1'b0;
      state_r     <= IDLE;
      bank_r      <= 1'b0;
      rd_idx_r    <= IDX_ZERO;
      valid_o     <= 1'b0;
      Sin_o       <= 32'd0;
      frame_cnt_o <= 16'd0;
    end else begin
      full_r <= full_nxt_s;
      if (wr_en_s) begin
        if (wr_last_s) begin
          wr_idx_r <= IDX_ZERO;
          cap_r    <= full_r[~cap_s] ? cap_s : ~cap_s;
        end else begin
          wr_idx_r <= wr_idx_r + IW'(1);
          cap_r    <= cap_s;
        end
      end else begin
        wr_idx_r <= wr_idx_r;
        cap_r    <= cap_r;
      end
      if (dec_valid_r && !wr_en_s) begin
        overflow_o <= 1'b1;
      end else begin
        overflow_o <= overflow_o;
      end
      case (state_r)
        IDLE: begin
          rd_idx_r <= IDX_ZERO;
          if (dtw_ready_i && (full_r != 2'b00)) begin
            state_r <= BURST;
            bank_r  <= sel_s;
            valid_o <= 1'b1;
            Sin_o   <= {2'b00, mem_r[sel_s][IDX_ZERO]};
          end else begin
            valid_o <= 1'b0;
            Sin_o   <= 32'd0;
          end
        end
        BURST: begin
          if (rd_idx_r == IDX_LAST) begin
            state_r     <= GAP;
            rd_idx_r    <= IDX_ZERO;
            valid_o     <= 1'b0;
            Sin_o       <= 32'd0;
            frame_cnt_o <= frame_cnt_o + 16'd1;
          end else begin
            rd_idx_r <= rd_idx_r + IW'(1);
            valid_o  <= 1'b1;
            Sin_o    <= {2'b00, mem_r[bank_r][rd_idx_r + IW'(1)]};
          end
        end
        GAP: begin
          state_r <= IDLE;
          valid_o <= 1'b0;
          Sin_o   <= 32'd0;
        end
        default: begin
          state_r <= IDLE;
          valid_o <= 1'b0;
          Sin_o   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_sample_framer.sv
// Directed bench for dtw_sample_framer: DECIM=1 instance for framing, ping-pong,
// overflow, ready gating and reset; a DECIM=4 instance for decimation.
module tb_dtw_sample_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sv_a, rdy_a, val_a, ovf_a;
  logic [9:0]  x_a, y_a, z_a;
  logic [31:0] sin_a;
  logic [15:0] fcnt_a;
  logic        sv_b, rdy_b, val_b, ovf_b;
  logic [9:0]  x_b, y_b, z_b;
  logic [31:0] sin_b;
  logic [15:0] fcnt_b;

  dtw_sample_framer #(.FRAME_LEN(20), .DECIM(1)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .smp_valid_i(sv_a),
    .smp_x_i(x_a), .smp_y_i(y_a), .smp_z_i(z_a), .dtw_ready_i(rdy_a),
    .valid_o(val_a), .Sin_o(sin_a), .overflow_o(ovf_a), .frame_cnt_o(fcnt_a)
  );

  dtw_sample_framer #(.FRAME_LEN(20), .DECIM(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .smp_valid_i(sv_b),
    .smp_x_i(x_b), .smp_y_i(y_b), .smp_z_i(z_b), .dtw_ready_i(rdy_b),
    .valid_o(val_b), .Sin_o(sin_b), .overflow_o(ovf_b), .frame_cnt_o(fcnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0;
  logic [31:0] q[$];
  int          qc[$];
  logic [31:0] qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (val_a) begin
      q.push_back(sin_a);
      qc.push_back(cyc);
    end
    if (val_b) qb.push_back(sin_b);
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y, input int z);
    return {2'b00, 10'(x), 10'(y), 10'(z)};
  endfunction

  task automatic send_a(input int x, input int y, input int z);
    @(negedge clk);
    sv_a = 1'b1; x_a = 10'(x); y_a = 10'(y); z_a = 10'(z);
  endtask

  task automatic idle_a();
    @(negedge clk);
    sv_a = 1'b0;
  endtask

  task automatic wait_n(input bit use_b, input int n, input int budget, input string tag);
    int i = 0;
    while (((use_b ? qb.size() : q.size()) < n) && (i < budget)) begin
      @(negedge clk); #1;
      i++;
    end
    check_value(tag, use_b ? qb.size() : q.size(), n);
  endtask

  task automatic clear_q();
    q.delete(); qc.delete(); qb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int xp[4];
    int yp[4];
    int zp[4];
    xp = '{1, 2, 3, 5};
    yp = '{8, 0, 0, 0};
    zp = '{3, 0, 0, 0};
    rst_n = 1'b0;
    sv_a = 1'b0; x_a = 10'd0; y_a = 10'd0; z_a = 10'd0; rdy_a = 1'b1;
    sv_b = 1'b0; x_b = 10'd0; y_b = 10'd0; z_b = 10'd0; rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    check_value("rst_valid", val_a, 0);
    check_value("rst_sin", sin_a, 0);
    check_value("rst_ovf", ovf_a, 0);
    check_value("rst_fcnt", fcnt_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with latency check
    clear_q();
    for (int k = 0; k < 20; k++) begin
      send_a(k, k, k);
      if (k == 19) c0 = cyc;
    end
    idle_a();
    wait_n(1'b0, 20, 40, "basic_burst");
    if (q.size() == 20) begin
      check_value("basic_latency", qc[0], c0 + 3);
      check_value("basic_len", qc[19] - qc[0], 19);
      check_value("basic_w1_lit", q[1], 32'h0010_0401);
      for (int i = 0; i < 20; i++) check_value($sformatf("basic_w%0d", i), q[i], pack(i, i, i));
    end
    repeat (3) @(negedge clk);
    check_value("basic_fcnt", fcnt_a, 1);
    check_value("basic_ovf", ovf_a, 0);

    // Ping-pong: 40 back-to-back samples
    clear_q();
    for (int k = 0; k < 40; k++) send_a(k + 100, 900 - k, k * 7);
    idle_a();
    wait_n(1'b0, 40, 80, "pp_burst");
    if (q.size() == 40) begin
      for (int i = 0; i < 40; i++) check_value($sformatf("pp_w%0d", i), q[i], pack(i + 100, 900 - i, i * 7));
      check_value("pp_len0", qc[19] - qc[0], 19);
      check_value("pp_len1", qc[39] - qc[20], 19);
      check_value("pp_gap", (qc[20] - qc[19]) >= 2, 1);
    end
    repeat (3) @(negedge clk);
    check_value("pp_ovf", ovf_a, 0);
    check_value("pp_fcnt", fcnt_a, 3);

    // Overflow with ready held low, then ready gating and mid-burst drop
    do_reset();
    clear_q();
    rdy_a = 1'b0;
    for (int s = 0; s < 41; s++) send_a(s, 2 * s, 3 * s);
    idle_a();
    repeat (5) @(negedge clk);
    #1;
    check_value("ovf_set", ovf_a, 1);
    check_value("ovf_no_valid", q.size(), 0);
    repeat (10) @(negedge clk);
    #1;
    check_value("gate_hold", q.size(), 0);
    rdy_a = 1'b1;
    wait_n(1'b0, 5, 10, "gate_start");
    rdy_a = 1'b0;
    wait_n(1'b0, 20, 30, "gate_full_burst");
    if (q.size() == 20) check_value("gate_len", qc[19] - qc[0], 19);
    repeat (10) @(negedge clk);
    #1;
    check_value("gate_hold2", q.size(), 20);
    rdy_a = 1'b1;
    wait_n(1'b0, 40, 40, "ovf_bank1");
    if (q.size() == 40) begin
      for (int i = 0; i < 40; i++) check_value($sformatf("ovf_w%0d", i), q[i], pack(i, 2 * i, 3 * i));
    end
    repeat (3) @(negedge clk);
    check_value("ovf_sticky", ovf_a, 1);
    check_value("ovf_fcnt", fcnt_a, 2);

    // Reset during burst word 7
    clear_q();
    for (int k = 0; k < 20; k++) send_a(k + 500, k + 300, k);
    idle_a();
    wait_n(1'b0, 8, 40, "rstmid_reach");
    check_value("rstmid_pre_valid", val_a, 1);
    rst_n = 1'b0;
    #1;
    check_value("rstmid_valid", val_a, 0);
    check_value("rstmid_sin", sin_a, 0);
    check_value("rstmid_fcnt", fcnt_a, 0);
    check_value("rstmid_ovf", ovf_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    for (int k = 0; k < 20; k++) send_a(k * 3, k * 5, 1000 - k);
    idle_a();
    wait_n(1'b0, 20, 40, "rstmid_fresh");
    if (q.size() == 20) begin
      for (int i = 0; i < 20; i++) check_value($sformatf("fresh_w%0d", i), q[i], pack(i * 3, i * 5, 1000 - i));
    end
    repeat (3) @(negedge clk);
    check_value("fresh_fcnt", fcnt_a, 1);

    // Decimation by 4 on the second instance
    clear_q();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      sv_b = 1'b1;
      x_b = 10'(xp[i % 4]); y_b = 10'(yp[i % 4]); z_b = 10'(zp[i % 4]);
      if (i == 78) begin
        repeat (5) begin
          @(negedge clk);
          sv_b = 1'b0;
        end
        #1;
        check_value("dec_no_early", qb.size(), 0);
      end
    end
    @(negedge clk);
    sv_b = 1'b0;
    wait_n(1'b1, 20, 40, "dec_burst");
    if (qb.size() == 20) begin
      for (int i = 0; i < 20; i++) check_value($sformatf("dec_w%0d", i), qb[i], pack(2, 2, 0));
    end
    repeat (3) @(negedge clk);
    check_value("dec_fcnt", fcnt_b, 1);
    check_value("dec_ovf", ovf_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
